// File: rtl/add_sub_scheduler.sv
// Two-requester round-robin front end that time-shares one sign-magnitude add_sub unit.
// Optional statistics counters are built only when ADD_SUB_STATS_EN is defined.

module add_sub (
    input  logic [2:0] num1,
    input  logic [2:0] num2,
    input  logic       selection,
    output logic [4:0] result,
    output logic       zeroflag
);
    logic       s1, s2, sign;
    logic [3:0] m1, m2, mag;

    always_comb begin
        m1 = {2'b00, num1[1:0]};
        m2 = {2'b00, num2[1:0]};
        // Subtraction flips the second operand's sign; a negative zero counts as positive.
        s1 = num1[2] & (num1[1:0] != 2'b00);
        s2 = (num2[2] ^ selection) & (num2[1:0] != 2'b00);
        if (s1 == s2) begin
            mag  = m1 + m2;
            sign = s1;
        end else if (m1 >= m2) begin
            mag  = m1 - m2;
            sign = s1;
        end else begin
            mag  = m2 - m1;
            sign = s2;
        end
        if (mag == '0) sign = 1'b0;
        result   = {sign, mag};
        zeroflag = (mag == '0);
    end
endmodule

module add_sub_scheduler #(
    parameter int EXEC_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_valid,
    output logic [1:0] req_ready,
    input  logic [2:0] req0_num1,
    input  logic [2:0] req0_num2,
    input  logic [2:0] req1_num1,
    input  logic [2:0] req1_num2,
    input  logic       req0_selection,
    input  logic       req1_selection,
    output logic       resp_valid,
    input  logic       resp_ready,
    output logic       resp_id,
    output logic [4:0] resp_result,
    output logic       resp_zeroflag,
    output logic       busy,
    output logic [7:0] op_count,
    output logic [7:0] zero_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [2:0] op1, op2;
    logic       op_sel, op_id;
    logic       prio;
    logic [1:0] grant;
    logic [4:0] as_result;
    logic       as_zero;

    add_sub u_add_sub (
        .num1      (op1),
        .num2      (op2),
        .selection (op_sel),
        .result    (as_result),
        .zeroflag  (as_zero)
    );

    // prio names the requester that wins when both are valid.
    always_comb begin
        grant = '0;
        if (state == IDLE) begin
            case (req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready  = grant;
    assign busy       = (state != IDLE);
    assign resp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op1           <= '0;
            op2           <= '0;
            op_sel        <= 1'b0;
            op_id         <= 1'b0;
            prio          <= 1'b0;
            resp_id       <= 1'b0;
            resp_result   <= '0;
            resp_zeroflag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant != 2'b00) begin
                        op_id  <= grant[1];
                        op1    <= grant[1] ? req1_num1 : req0_num1;
                        op2    <= grant[1] ? req1_num2 : req0_num2;
                        op_sel <= grant[1] ? req1_selection : req0_selection;
                        prio   <= ~grant[1];
                        cnt    <= 4'(EXEC_CYCLES);
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        resp_id       <= op_id;
                        resp_result   <= as_result;
                        resp_zeroflag <= as_zero;
                        state         <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ADD_SUB_STATS_EN
    logic [7:0] op_cnt, zero_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_cnt   <= '0;
            zero_cnt <= '0;
        end else if (state == RESP && resp_ready) begin
            if (op_cnt != '1) op_cnt <= op_cnt + 8'd1;
            if (resp_zeroflag && zero_cnt != '1) zero_cnt <= zero_cnt + 8'd1;
        end
    end

    assign op_count   = op_cnt;
    assign zero_count = zero_cnt;
`else
    assign op_count   = '0;
    assign zero_count = '0;
`endif
endmodule
